// File: rtl/branch_predict_hazard_ctrl.sv
// Fetch-side control-hazard unit: PC-indexed BHT of saturating counters drives next PC and wrong-path squash.
// Latency: outputs combinational from pc/state; branch resolves the cycle after acceptance. No backpressure (flush aborts).
// Optional BHT_STATS_EN macro adds saturating resolved-branch and misprediction counters.
module branch_predict_hazard_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              BHT_ENTRIES  = 16,
    parameter int              CTR_BITS     = 2,
    parameter logic [XLEN-1:0] PC_DONT_CARE = 32'hFFFF00FF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            is_branch,
    input  logic            compflg,
    input  logic [XLEN-1:0] pc,
    input  logic            actual_taken,
    input  logic [XLEN-1:0] calculated_target_pc,
    output logic [XLEN-1:0] pc_next,
    output logic            squash_for_wrong_pdctn,
    output logic            predict_taken
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int                   IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef enum logic [1:0] {IDLE, PRED_NT, PRED_T} state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                compflg_q, compflg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
    logic [CTR_BITS-1:0] bht_d [BHT_ENTRIES];

    logic [IDX_W-1:0]    lookup_idx;
    logic [XLEN-1:0]     pc_seq, pc_q_seq;
    logic                accept;
    logic                upd_en;
    logic [CTR_BITS-1:0] cur_ctr;

    // Halfword-granular index so compressed instructions get distinct entries.
    assign lookup_idx    = pc[IDX_W:1];
    assign predict_taken = bht_q[lookup_idx][CTR_BITS-1];
    assign pc_seq        = pc + (compflg ? XLEN'(2) : XLEN'(4));
    assign pc_q_seq      = pc_q + (compflg_q ? XLEN'(2) : XLEN'(4));
    assign cur_ctr       = bht_q[idx_q];

    always_comb begin
        state_d                = state_q;
        pc_d                   = pc_q;
        compflg_d              = compflg_q;
        idx_d                  = idx_q;
        pc_next                = PC_DONT_CARE;
        squash_for_wrong_pdctn = 1'b0;
        accept                 = 1'b0;
        upd_en                 = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_branch) begin
                        accept  = 1'b1;
                        pc_next = predict_taken ? PC_DONT_CARE : pc_seq;
                    end
                end
                PRED_NT: begin
                    upd_en = 1'b1;
                    if (actual_taken) begin
                        pc_next                = calculated_target_pc;
                        squash_for_wrong_pdctn = 1'b1;
                        state_d                = IDLE;
                    end else begin
                        pc_next = pc_seq;
                        if (is_branch) begin
                            accept  = 1'b1;
                            pc_next = predict_taken ? PC_DONT_CARE : pc_seq;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                PRED_T: begin
                    // Whatever sits in IF was fetched on the bubble path, so it is always killed.
                    upd_en                 = 1'b1;
                    pc_next                = actual_taken ? calculated_target_pc : pc_q_seq;
                    squash_for_wrong_pdctn = 1'b1;
                    state_d                = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            state_d   = predict_taken ? PRED_T : PRED_NT;
            pc_d      = pc;
            compflg_d = compflg;
            idx_d     = lookup_idx;
        end
        if (!reset_n) begin
            pc_next                = PC_DONT_CARE;
            squash_for_wrong_pdctn = 1'b0;
        end
    end

    // Prediction above reads bht_q, so a same-index lookup sees the pre-update count.
    always_comb begin
        bht_d = bht_q;
        if (upd_en) begin
            if (actual_taken && cur_ctr != CTR_MAX)
                bht_d[idx_q] = cur_ctr + 1'b1;
            else if (!actual_taken && cur_ctr != '0)
                bht_d[idx_q] = cur_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            compflg_q <= 1'b0;
            idx_q     <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= CTR_INIT;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            compflg_q <= compflg_d;
            idx_q     <= idx_d;
            bht_q     <= bht_d;
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_en) begin
            if (stat_branches_q != 32'hFFFFFFFF)
                stat_branches_d = stat_branches_q + 32'd1;
            if (actual_taken != (state_q == PRED_T) && stat_mispredicts_q != 32'hFFFFFFFF)
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_hazard_ctrl.sv
// Bench for branch_predict_hazard_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_branch_predict_hazard_ctrl;

    localparam logic [31:0] DC = 32'hFFFF00FF;

    logic        clk = 1'b0;
    logic        reset_n, flush, is_branch, compflg, actual_taken;
    logic [31:0] pc, calculated_target_pc, pc_next;
    logic        squash_for_wrong_pdctn, predict_taken;
`ifdef BHT_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
    int          m_br, m_mis;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: counter values per entry and the outstanding prediction (0 none, 1 not-taken, 2 taken).
    int          ctr [16];
    int          pend;
    logic [31:0] spc;
    logic        scf;

    logic [31:0] obs_next;
    logic        obs_sq, obs_pred;

    always #5 clk = ~clk;

    branch_predict_hazard_ctrl dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .flush                  (flush),
        .is_branch              (is_branch),
        .compflg                (compflg),
        .pc                     (pc),
        .actual_taken           (actual_taken),
        .calculated_target_pc   (calculated_target_pc),
        .pc_next                (pc_next),
        .squash_for_wrong_pdctn (squash_for_wrong_pdctn),
        .predict_taken          (predict_taken)
`ifdef BHT_STATS_EN
        ,
        .stat_branches          (stat_branches),
        .stat_mispredicts       (stat_mispredicts)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] seq_pc(input logic [31:0] a, input logic c);
        return a + (c ? 32'd2 : 32'd4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ctr[i] = 1;
        pend = 0;
        spc  = '0;
        scf  = 1'b0;
`ifdef BHT_STATS_EN
        m_br  = 0;
        m_mis = 0;
`endif
    endtask

    // One cycle: drive at negedge, check combinational outputs, commit model at posedge.
    task automatic step(input logic rn, input logic fl, input logic br, input logic cf,
                        input logic at, input logic [31:0] p, input logic [31:0] tgt);
        logic [31:0] e_next, n_spc;
        logic        e_sq, e_pred, n_scf, upd;
        int          n_pend, uidx, uval;
        reset_n = rn; flush = fl; is_branch = br; compflg = cf;
        actual_taken = at; pc = p; calculated_target_pc = tgt;
        #1;
        if (!rn) model_reset();
        e_pred = ctr[p[4:1]] >= 2;
        e_next = DC; e_sq = 1'b0; upd = 1'b0; uidx = 0; uval = 0;
        n_pend = pend; n_spc = spc; n_scf = scf;
        if (rn && fl) begin
            n_pend = 0;
        end else if (rn && pend == 0) begin
            if (br) begin
                n_pend = e_pred ? 2 : 1; n_spc = p; n_scf = cf;
                e_next = e_pred ? DC : seq_pc(p, cf);
            end
        end else if (rn) begin
            upd  = 1'b1;
            uidx = int'(spc[4:1]);
            uval = at ? ((ctr[uidx] < 3) ? ctr[uidx] + 1 : 3) : ((ctr[uidx] > 0) ? ctr[uidx] - 1 : 0);
            n_pend = 0;
            if (at) begin
                e_next = tgt; e_sq = 1'b1;
            end else if (pend == 2) begin
                e_next = seq_pc(spc, scf); e_sq = 1'b1;
            end else begin
                e_next = seq_pc(p, cf);
                if (br) begin
                    n_pend = e_pred ? 2 : 1; n_spc = p; n_scf = cf;
                    e_next = e_pred ? DC : seq_pc(p, cf);
                end
            end
        end
        check_eq("predict_taken", {31'd0, predict_taken}, {31'd0, e_pred});
        check_eq("pc_next", pc_next, e_next);
        check_eq("squash", {31'd0, squash_for_wrong_pdctn}, {31'd0, e_sq});
`ifdef BHT_STATS_EN
        check_eq("stat_branches", stat_branches, m_br);
        check_eq("stat_mispredicts", stat_mispredicts, m_mis);
`endif
        obs_next = pc_next; obs_sq = squash_for_wrong_pdctn; obs_pred = predict_taken;
        @(posedge clk);
        if (rn) begin
            if (upd) begin
`ifdef BHT_STATS_EN
                m_br++;
                if (at != (pend == 2)) m_mis++;
`endif
                ctr[uidx] = uval;
            end
            pend = n_pend; spc = n_spc; scf = n_scf;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0; flush = 0; is_branch = 0; compflg = 0; actual_taken = 0;
        pc = '0; calculated_target_pc = '0;
        @(negedge clk);

        // Reset and first not-taken prediction, then taken resolution.
        step(0, 0, 1, 0, 0, 32'h100, 0);
        check_eq("t1_reset_pc_next", obs_next, DC);
        step(1, 0, 1, 0, 0, 32'h100, 0);
        check_eq("t1_pred", {31'd0, obs_pred}, 32'd0);
        check_eq("t1_pc_next", obs_next, 32'h104);
        step(1, 0, 0, 0, 1, 32'h104, 32'h80);
        check_eq("t1_redirect", obs_next, 32'h80);
        check_eq("t1_squash", {31'd0, obs_sq}, 32'd1);

        // Same branch now predicted taken; resolves not-taken.
        step(1, 0, 1, 0, 0, 32'h100, 0);
        check_eq("t2_pred", {31'd0, obs_pred}, 32'd1);
        check_eq("t2_bubble", obs_next, DC);
        step(1, 0, 0, 0, 0, 32'h80, 32'h80);
        check_eq("t2_recover", obs_next, 32'h104);
        check_eq("t2_squash", {31'd0, obs_sq}, 32'd1);
`ifdef BHT_STATS_EN
        check_eq("t6_branches", stat_branches, 32'd2);
        check_eq("t6_mispredicts", stat_mispredicts, 32'd2);
`endif
        step(1, 0, 0, 0, 0, 32'h100, 0);
        check_eq("t2_ctr_down", {31'd0, obs_pred}, 32'd0);

        // Saturation at index 3.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0, 32'h106, 0);
            step(1, 0, 0, 0, 1, 32'h40, 32'h40);
        end
        step(1, 0, 0, 0, 0, 32'h106, 0);
        check_eq("t3_sat_hi", {31'd0, obs_pred}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0, 32'h106, 0);
            step(1, 0, 0, 0, 0, 32'h40, 32'h40);
        end
        step(1, 0, 1, 0, 0, 32'h106, 0);
        step(1, 0, 0, 0, 1, 32'h40, 32'h40);
        step(1, 0, 0, 0, 0, 32'h106, 0);
        check_eq("t3_sat_lo", {31'd0, obs_pred}, 32'd0);

        // Compressed back-to-back not-taken chain.
        step(1, 0, 1, 1, 0, 32'h202, 0);
        check_eq("t4_first", obs_next, 32'h204);
        step(1, 0, 1, 1, 0, 32'h204, 0);
        check_eq("t4_chain", obs_next, 32'h206);
        check_eq("t4_nosquash", {31'd0, obs_sq}, 32'd0);
        step(1, 0, 0, 1, 0, 32'h206, 0);
        check_eq("t4_end", obs_next, 32'h208);

        // Flush in PRED_T leaves counter alone; reset mid-PRED_NT restores table.
        step(1, 0, 1, 0, 0, 32'h10A, 0);
        step(1, 0, 0, 0, 1, 32'h20, 32'h20);
        step(1, 0, 1, 0, 0, 32'h10A, 0);
        step(1, 1, 0, 0, 1, 32'h20, 32'h20);
        check_eq("t5_flush_pc", obs_next, DC);
        check_eq("t5_flush_sq", {31'd0, obs_sq}, 32'd0);
        step(1, 0, 0, 0, 0, 32'h10A, 0);
        check_eq("t5_ctr_kept", {31'd0, obs_pred}, 32'd1);
        step(1, 0, 1, 0, 0, 32'h300, 0);
        step(0, 0, 0, 0, 1, 32'h10A, 32'h20);
        check_eq("t5_rst_sq", {31'd0, obs_sq}, 32'd0);
        step(1, 0, 0, 0, 0, 32'h10A, 0);
        check_eq("t5_ctr_reinit", {31'd0, obs_pred}, 32'd0);

        // Address-space wrap.
        step(1, 0, 1, 0, 0, 32'hFFFFFFFC, 0);
        check_eq("t6_wrap", obs_next, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 0);

        // Random traffic over a small PC window so counters are revisited often.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 49) == 0) ? (32'hFFFFFFF0 + 2 * $urandom_range(0, 7))
                                              : (32'h1000 + 2 * $urandom_range(0, 31));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 6), 1'($urandom), 1'($urandom), rp, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
